// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache miss/write requests onto one pipelined memory port,
// issuing block fills word by word and steering returned words into the target cache.
module mem_arbiter #(
    parameter int  BLOCK_WORDS = 8,
    localparam int IDXW        = $clog2(BLOCK_WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [15:0]     i_addr,
    input  logic            d_req,
    input  logic            d_wr,
    input  logic [15:0]     d_addr,
    input  logic [15:0]     d_wdata,
    output logic            mem_en,
    output logic            mem_wr,
    output logic [15:0]     mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic            mem_valid,
    input  logic [15:0]     mem_rdata,
    output logic            fill_we,
    output logic            fill_sel,
    output logic [IDXW-1:0] fill_idx,
    output logic [15:0]     fill_data,
    output logic            i_done,
    output logic            d_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BLOCK_WORDS - 1);
    localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);

    state_t          state_q, state_d;
    logic            tgt_q, tgt_d;
    logic            last_d_q, last_d_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [IDXW-1:0] issue_cnt_q, issue_cnt_d;
    logic            issue_busy_q, issue_busy_d;
    logic [IDXW-1:0] ret_cnt_q, ret_cnt_d;

    logic            grant_i_s;
    logic            grant_d_s;
    logic            fill_hit_s;
    logic            last_ret_s;
    logic            issuing_s;
    logic            writing_s;

    // last_d_q remembers which side won the previous grant so a tie goes to the other side
    assign grant_d_s  = d_req && (!i_req || !last_d_q);
    assign grant_i_s  = i_req && (!d_req || last_d_q);
    assign fill_hit_s = (state_q == ST_FILL) && mem_valid;
    assign last_ret_s = fill_hit_s && (ret_cnt_q == LAST_IDX);
    assign issuing_s  = (state_q == ST_FILL) && issue_busy_q;
    assign writing_s  = (state_q == ST_WRITE);

    // Next-state logic for the transaction FSM and its counters
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        last_d_d     = last_d_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        issue_cnt_d  = issue_cnt_q;
        issue_busy_d = issue_busy_q;
        ret_cnt_d    = ret_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_d      = d_wr ? ST_WRITE : ST_FILL;
                    tgt_d        = 1'b1;
                    last_d_d     = 1'b1;
                    addr_d       = d_addr;
                    wdata_d      = d_wdata;
                    issue_cnt_d  = '0;
                    issue_busy_d = !d_wr;
                    ret_cnt_d    = '0;
                end else if (grant_i_s) begin
                    state_d      = ST_FILL;
                    tgt_d        = 1'b0;
                    last_d_d     = 1'b0;
                    addr_d       = i_addr;
                    issue_cnt_d  = '0;
                    issue_busy_d = 1'b1;
                    ret_cnt_d    = '0;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (issue_busy_q) begin
                    issue_cnt_d  = issue_cnt_q + ONE_IDX;
                    issue_busy_d = (issue_cnt_q != LAST_IDX);
                end else begin
                    issue_busy_d = 1'b0;
                end
                if (fill_hit_s) begin
                    ret_cnt_d = ret_cnt_q + ONE_IDX;
                end else begin
                    ret_cnt_d = ret_cnt_q;
                end
                state_d = last_ret_s ? ST_IDLE : ST_FILL;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tgt_q        <= 1'b0;
            last_d_q     <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            issue_cnt_q  <= '0;
            issue_busy_q <= 1'b0;
            ret_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            last_d_q     <= last_d_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            issue_cnt_q  <= issue_cnt_d;
            issue_busy_q <= issue_busy_d;
            ret_cnt_q    <= ret_cnt_d;
        end
    end

    // Output decode; fill strobes follow mem_valid in the same cycle
    always_comb begin
        mem_en    = issuing_s || writing_s;
        mem_wr    = writing_s;
        fill_we   = fill_hit_s;
        fill_data = mem_rdata;
        i_done    = last_ret_s && !tgt_q;
        d_done    = (last_ret_s && tgt_q) || writing_s;
        if (writing_s) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end else if (issuing_s) begin
            mem_addr  = {addr_q[15:IDXW+1], issue_cnt_q, 1'b0};
            mem_wdata = 16'h0000;
        end else begin
            mem_addr  = 16'h0000;
            mem_wdata = 16'h0000;
        end
        if (fill_hit_s) begin
            fill_sel = tgt_q;
            fill_idx = ret_cnt_q;
        end else begin
            fill_sel = 1'b0;
            fill_idx = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a write-path vector table plus hand-built fill
// sequences with a fixed 4-cycle memory latency.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic        fill_we;
    logic        fill_sel;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;

    int pass_cnt;
    int total_cnt;

    mem_arbiter #(.BLOCK_WORDS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .fill_we   (fill_we),
        .fill_sel  (fill_sel),
        .fill_idx  (fill_idx),
        .fill_data (fill_data),
        .i_done    (i_done),
        .d_done    (d_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        i_req;
        logic [15:0] i_addr;
        logic        d_req;
        logic        d_wr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        mv;
        logic [15:0] rd;
        logic        en;
        logic        wr;
        logic [15:0] ea;
        logic [15:0] ew;
        logic        dd;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input string nm, input logic ir, input logic [15:0] ia,
                                input logic dr, input logic dw, input logic [15:0] da,
                                input logic [15:0] dwd, input logic mv, input logic [15:0] rd,
                                input logic en, input logic wr, input logic [15:0] ea,
                                input logic [15:0] ew, input logic dd);
        vec_t v;
        v.nm = nm; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_wr = dw;
        v.d_addr = da; v.d_wdata = dwd; v.mv = mv; v.rd = rd;
        v.en = en; v.wr = wr; v.ea = ea; v.ew = ew; v.dd = dd;
        return v;
    endfunction

    function automatic logic [56:0] pk(input logic en, input logic wr, input logic [15:0] addr,
                                       input logic [15:0] wdata, input logic we, input logic sel,
                                       input logic [2:0] idx, input logic idn, input logic ddn,
                                       input logic [15:0] fd);
        return {en, wr, addr, wdata, we, sel, idx, idn, ddn, fd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [56:0] exp);
        logic [56:0] got;
        @(negedge clk);
        got = {mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel, fill_idx,
               i_done, d_done, fill_data};
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (en,wr,addr,wdata,we,sel,idx,idone,ddone,fdata)",
                     nm, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Starts in the grant cycle; walks the 8 issues and 8 returns (latency LAT).
    task automatic fill_seq(input string tag, input logic [15:0] base, input logic sel,
                            input logic drop, input int abort_at);
        logic       iss;
        logic       ret;
        logic       lst;
        logic [15:0] ea;
        chk({tag, "_grant"}, pk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0,
                                1'b0, 1'b0, mem_rdata));
        for (int k = 0; k < LAT + 8; k++) begin
            step();
            if (drop && k == 0) begin
                if (sel) d_req = 1'b0;
                else     i_req = 1'b0;
            end
            mem_valid = (k >= LAT) ? 1'b1 : 1'b0;
            mem_rdata = mem_valid ? (16'hA000 ^ (base + 16'(2 * (k - LAT)))) : 16'h0000;
            if (k == abort_at) begin
                rst_n = 1'b0;
                chk($sformatf("%s_rst_k%0d", tag, k),
                    pk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, mem_rdata));
                return;
            end
            iss = (k < 8);
            ret = (k >= LAT);
            lst = (k == LAT + 7);
            ea  = iss ? (base + 16'(2 * k)) : 16'h0000;
            chk($sformatf("%s_k%0d", tag, k),
                pk(iss, 1'b0, ea, 16'h0000, ret, ret ? sel : 1'b0,
                   ret ? 3'(k - LAT) : 3'd0, lst && !sel, lst && sel, mem_rdata));
        end
        step();
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        if (sel) d_req = 1'b0;
        else     i_req = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_addr    = 16'h0000;
        d_req     = 1'b0;
        d_wr      = 1'b0;
        d_addr    = 16'h0000;
        d_wdata   = 16'h0000;
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;

        vecs[0] = mk("idle_stray",  1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h7777,
                     1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[1] = mk("wr_grant",    1'b0, 16'h0000, 1'b1, 1'b1, 16'h00F2, 16'hBEEF, 1'b0, 16'h0000,
                     1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[2] = mk("wr_issue",    1'b0, 16'h0000, 1'b1, 1'b1, 16'h00F2, 16'hBEEF, 1'b0, 16'h0000,
                     1'b1, 1'b1, 16'h00F2, 16'hBEEF, 1'b1);
        vecs[3] = mk("wr_after",    1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111,
                     1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[4] = mk("wr2_grant",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h5A5A, 1'b0, 16'h0000,
                     1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[5] = mk("wr2_issue",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h5A5A, 1'b1, 16'h2222,
                     1'b1, 1'b1, 16'h1234, 16'h5A5A, 1'b1);
        vecs[6] = mk("wr3_grant",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0ABC, 16'hFFFF, 1'b0, 16'h0000,
                     1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[7] = mk("wr3_issue",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0ABC, 16'hFFFF, 1'b0, 16'h0000,
                     1'b1, 1'b1, 16'h0ABC, 16'hFFFF, 1'b1);

        step();
        i_req = 1'b1;
        i_addr = 16'h1234;
        chk("reset_state", pk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000));
        step();
        rst_n = 1'b1;
        fill_seq("i_fill", 16'h1230, 1'b0, 1'b0, -1);

        rst_n = 1'b0;
        chk("reset_again", pk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000));
        step();
        rst_n  = 1'b1;
        i_req  = 1'b1;
        i_addr = 16'h4446;
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h8000;
        fill_seq("tie_d", 16'h8000, 1'b1, 1'b0, -1);
        fill_seq("then_i", 16'h4440, 1'b0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            i_req     = vecs[r].i_req;
            i_addr    = vecs[r].i_addr;
            d_req     = vecs[r].d_req;
            d_wr      = vecs[r].d_wr;
            d_addr    = vecs[r].d_addr;
            d_wdata   = vecs[r].d_wdata;
            mem_valid = vecs[r].mv;
            mem_rdata = vecs[r].rd;
            chk(vecs[r].nm, pk(vecs[r].en, vecs[r].wr, vecs[r].ea, vecs[r].ew, 1'b0, 1'b0, 3'd0,
                               1'b0, vecs[r].dd, vecs[r].rd));
            step();
        end

        i_req     = 1'b1;
        i_addr    = 16'h1234;
        d_req     = 1'b1;
        d_wr      = 1'b0;
        d_addr    = 16'h8000;
        d_wdata   = 16'h0000;
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        fill_seq("tie_i_drop", 16'h1230, 1'b0, 1'b1, -1);
        fill_seq("d_after", 16'h8000, 1'b1, 1'b0, -1);

        i_req  = 1'b1;
        i_addr = 16'h1234;
        fill_seq("rst_mid", 16'h1230, 1'b0, 1'b0, LAT + 2);
        step();
        mem_valid = 1'b1;
        mem_rdata = 16'h3333;
        chk("rst_low_stray", pk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h3333));
        step();
        rst_n     = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 16'h4444;
        fill_seq("refill", 16'h1230, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 8, meaning words per cache block; SHALL be a power of two, and IDXW = log2(BLOCK_WORDS).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  I-cache miss request; held high until i_done.
REQ-005 i_addr  input  16  I-side miss byte address.
REQ-006 d_req  input  1  D-side request (miss fill or write); held high until d_done.
REQ-007 d_wr  input  1  D-side request is a single-word write-through (1) or block fill (0).
REQ-008 d_addr  input  16  D-side byte address.
REQ-009 d_wdata  input  16  D-side write data.
REQ-010 mem_en  output  1  memory access issue strobe.
REQ-011 mem_wr  output  1  issued access is a write.
REQ-012 mem_addr  output  16  memory byte address.
REQ-013 mem_wdata  output  16  memory write data.
REQ-014 mem_valid  input  1  read data returning from memory (pipelined, fixed latency, in issue order).
REQ-015 mem_rdata  input  16  returned read data.
REQ-016 fill_we  output  1  write one fill word into the target cache.
REQ-017 fill_sel  output  1  fill target: 0 = I-cache, 1 = D-cache.
REQ-018 fill_idx  output  IDXW  word index within the block for fill_we.
REQ-019 fill_data  output  16  fill word (equals mem_rdata).
REQ-020 i_done, d_done  output  1 each  single-cycle completion pulses.

Function
REQ-021 States: IDLE, FILL, WRITE; the block SHALL hold exactly one transaction in flight.
REQ-022 In IDLE with one request pending, the block SHALL grant it; with both pending, the block SHALL grant the side not granted last (last-grant flag reset to I, so D wins the first tie).
REQ-023 A D grant with d_wr=1 SHALL go IDLE->WRITE; any other grant SHALL go IDLE->FILL; the base address (addr[15:4] with BLOCK_WORDS=8) and target SHALL be latched at grant.
REQ-024 WRITE SHALL last one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_done=1, then IDLE.
REQ-025 FILL issue phase: for BLOCK_WORDS consecutive cycles starting the cycle after grant, mem_en=1, mem_wr=0, mem_addr={base, issue_cnt, 1'b0}, issue_cnt counting 0..BLOCK_WORDS-1.
REQ-026 In FILL, each mem_valid cycle SHALL assert fill_we, fill_sel=target, fill_idx=ret_cnt, fill_data=mem_rdata, and increment ret_cnt; returns overlapping the issue phase SHALL be accepted.
REQ-027 In the cycle the last word is returned (ret_cnt=BLOCK_WORDS-1 with mem_valid), the block SHALL pulse i_done or d_done per target and go to IDLE next cycle; a new grant SHALL NOT occur before then.
REQ-028 mem_valid outside FILL, or after the last word, SHALL be ignored (no fill_we).
REQ-029 A request deasserted mid-transaction SHALL NOT abort it; the transaction completes and the done pulse still fires.
REQ-030 Counters SHALL wrap cleanly at IDXW bits; the address low bit SHALL always be 0.
REQ-031 Outputs other than fill_data/mem_wdata SHALL be 0 whenever not asserted by REQ-024..026.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, clear counters and last-grant flag, and drive mem_en, mem_wr, fill_we, i_done, d_done low, with mem_addr, mem_wdata, fill_idx, and fill_sel at 0.
REQ-033 Reset mid-FILL SHALL discard the transaction; words returned after release SHALL be ignored; a still-pending request SHALL be re-granted from word 0.

Verification
REQ-034 i_req, i_addr=0x1234, latency 4 -> mem_addr 0x1230,0x1232..0x123E on 8 cycles; fill_idx 0..7 with fill_sel=0; i_done pulses with the 8th return.
REQ-035 i_req and d_req (fill, 0x8000) rise together after reset -> D filled first (0x8000..0x800E), then I; next simultaneous tie -> I first.
REQ-036 d_req, d_wr=1, d_addr=0x00F2, d_wdata=0xBEEF -> one cycle mem_en=1, mem_wr=1, addr 0x00F2, data 0xBEEF, d_done same cycle.
REQ-037 rst_n low on the 3rd return of an I fill -> outputs 0 at once; stray mem_valid ignored; after release the held i_req refills from 0x1230.
REQ-038 i_req dropped after grant; d_req pending -> I fill completes with i_done; D granted only in the IDLE cycle afterward.
